alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have these ports, clock and reset first, one line each: name  direction  width  meaning.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low, sampled on the rising edge of clk.
REQ-004 req0_valid / req1_valid  input  1  requester 0 (execute stage) / requester 1 (trace/debug port) has an operation.
REQ-005 req0_ready / req1_ready  output  1  block accepts that requester's operation this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  32  operands.
REQ-007 req0_op, req1_op  input  5  ALU opcode (0x00 add .. 0x0C lui; other values illegal).
REQ-008 alu_a, alu_b  output  32  operands driven to the shared ALU.
REQ-009 alu_op  output  5  opcode driven to the shared ALU.
REQ-010 alu_result  input  32  combinational result from the shared ALU.
REQ-011 alu_branch  input  1  combinational branch flag from the shared ALU.
REQ-012 rsp_valid  output  1  response register holds a result.
REQ-013 rsp_ready  input  1  consumer takes the response this cycle.
REQ-014 rsp_id  output  1  requester that owns the response.
REQ-015 rsp_result  output  32  registered ALU result.
REQ-016 rsp_branch  output  1  registered branch flag.
REQ-017 rsp_err  output  1  registered illegal-opcode flag.
REQ-018 No parameters; one build-time macro (REQ-035).

Function
REQ-019 States: IDLE (response register empty) and FULL (response register holds an unconsumed result).
REQ-020 Slot free = IDLE, or FULL with rsp_ready=1 (drain and refill in the same cycle).
REQ-021 Grant: at most one of req0_ready/req1_ready is 1 per cycle; it is 1 only when the slot is free and the matching valid is 1.
REQ-022 Round-robin: if both valid, grant the port not granted last; last_grant resets to 1, so port 0 wins the first contention.
REQ-023 If only one port is valid, that port is granted regardless of last_grant; last_grant updates only on an actual grant.
REQ-024 alu_a/alu_b/alu_op SHALL carry the granted port's operands, else requester 0's operands (deterministic, no X).
REQ-025 On a grant at edge N, rsp_result, rsp_id and rsp_err are loaded and rsp_valid=1 from cycle N+1: latency 1 cycle; throughput 1 op/cycle while rsp_ready=1.
REQ-026 rsp_branch = alu_branch for opcodes 0x08-0x0B; forced 0 for all other opcodes.
REQ-027 Opcode >0x0C: accepted, rsp_result=0, rsp_branch=0, rsp_err=1; never stalls.
REQ-028 FULL with rsp_ready=0: outputs held stable, both readies 0, requests wait; a valid request is never dropped or reordered.
REQ-029 FULL with rsp_ready=1 and no grant: go to IDLE, rsp_valid=0 next cycle.
REQ-030 Requester operands are sampled only in the grant cycle; changes while not granted have no effect.

Reset
REQ-031 While rst_n=0 at an edge: state IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_branch=0, rsp_err=0, last_grant=1.
REQ-032 During reset, req0_ready=req1_ready=0, regardless of valids.
REQ-033 Reset mid-operation discards any held response without delivering it; first grant is possible in the first cycle after rst_n returns to 1.
REQ-034 No asynchronous reset path exists.

Configuration
REQ-035 Macro ALU_ARB_FIXED_PRIO_EN: when defined, requester 0 always wins contention (last_grant unused, held at reset value); when undefined, the round-robin of REQ-022 applies.

Verification
REQ-036 Reset, then both valid, ops add 5+7 (p0) and sub 9-4 (p1), rsp_ready=1 -> cycle 1 rsp id0 result 12, cycle 2 rsp id1 result 5.
REQ-037 rsp_ready=0 for 3 cycles after one grant -> rsp_valid held 1, result stable, both readies 0; release -> next grant same cycle.
REQ-038 p0 beq a=b=3, then p0 add 1+1 -> rsp_branch 1 then 0 (not stale).
REQ-039 p1 op 0x1F -> rsp_err=1, result 0, branch 0, no stall.
REQ-040 rst_n=0 asserted while FULL -> rsp_valid=0 next cycle; with ALU_ARB_FIXED_PRIO_EN defined, 4 contended cycles -> all grants to p0.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : alu_arbiter                                                    |
// | Purpose : Two-requester arbiter for a shared combinational ALU with a    |
// |           single-entry registered response slot (round-robin grant).     |
// | Macro   : ALU_ARB_FIXED_PRIO_EN - requester 0 always wins contention.    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [4:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req1_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_branch,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_branch,
  output logic        rsp_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  localparam logic [4:0] OP_LAST_LEGAL = 5'h0C;
  localparam logic [4:0] OP_BR_FIRST   = 5'h08;
  localparam logic [4:0] OP_BR_LAST    = 5'h0B;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;   // 1 = port 1 was granted last
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_branch_q, rsp_branch_d;
  logic        rsp_err_q, rsp_err_d;

  logic        slot_free;
  logic        prefer0;
  logic        grant0;
  logic        grant1;
  logic        op_legal;
  logic        op_is_branch;

  // Arbitration and ALU operand steering; readies are forced low while in reset.
  always_comb begin
    slot_free = (state_q == ST_IDLE) || rsp_ready;
    // In fixed-priority builds last_grant never leaves 1, so port 0 always wins.
    prefer0   = last_grant_q;
    grant0    = rst_n && slot_free && req0_valid && (!req1_valid || prefer0);
    grant1    = rst_n && slot_free && req1_valid && (!req0_valid || !prefer0);
    alu_a     = grant1 ? req1_a  : req0_a;
    alu_b     = grant1 ? req1_b  : req0_b;
    alu_op    = grant1 ? req1_op : req0_op;
    op_legal     = (alu_op <= OP_LAST_LEGAL);
    op_is_branch = (alu_op >= OP_BR_FIRST) && (alu_op <= OP_BR_LAST);
  end

  // Next-state and response-slot load logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_branch_d = rsp_branch_q;
    rsp_err_d    = rsp_err_q;
    if (grant0 || grant1) begin
      state_d      = ST_FULL;
      rsp_id_d     = grant1;
      rsp_result_d = op_legal ? alu_result : 32'h0;
      rsp_branch_d = op_is_branch ? alu_branch : 1'b0;
      rsp_err_d    = !op_legal;
`ifdef ALU_ARB_FIXED_PRIO_EN
      last_grant_d = 1'b1;
`else
      last_grant_d = grant1;
`endif
    end else if ((state_q == ST_FULL) && rsp_ready) begin
      state_d = ST_IDLE;
    end
  end

  // State and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 32'h0;
      rsp_branch_q <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_branch_q <= rsp_branch_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = (state_q == ST_FULL);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_branch = rsp_branch_q;
  assign rsp_err    = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_alu_arbiter                                                 |
// | Purpose : Scoreboard bench for alu_arbiter with a behavioural ALU and    |
// |           arbitration reference model.                                   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_alu_arbiter;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
  } op_t;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic        br;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_op;
  logic        alu_branch;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_branch, rsp_err;
  logic [31:0] rsp_result;

  int   checks = 0;
  int   errors = 0;
  bit   run = 1'b0;
  bit   gate_all = 1'b1;
  int   ready_pct = 100;
  bit   acc0, acc1;
  bit   model_full;
  bit   last_gnt_m;
  op_t  opq0[$];
  op_t  opq1[$];
  exp_t sb[$];

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_branch(alu_branch),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_branch(rsp_branch), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Shared ALU: {branch, result}. Non-branch and illegal opcodes still produce
  // a non-trivial branch flag / result so the arbiter's masking is visible.
  function automatic logic [32:0] alu_model(logic [31:0] a, logic [31:0] b, logic [4:0] op);
    logic [31:0] r;
    logic        br;
    br = a[0] | b[0];
    case (op)
      5'h00: r = a + b;
      5'h01: r = a - b;
      5'h02: r = a & b;
      5'h03: r = a | b;
      5'h04: r = a ^ b;
      5'h05: r = a << b[4:0];
      5'h06: r = a >> b[4:0];
      5'h07: r = $unsigned($signed(a) >>> b[4:0]);
      5'h08: begin r = a - b; br = (a == b); end
      5'h09: begin r = a - b; br = (a != b); end
      5'h0A: begin r = a - b; br = ($signed(a) < $signed(b)); end
      5'h0B: begin r = a - b; br = ($signed(a) >= $signed(b)); end
      5'h0C: r = b << 12;
      default: begin r = a ^ b ^ 32'hDEADBEEF; br = 1'b1; end
    endcase
    return {br, r};
  endfunction

  function automatic exp_t expect_rsp(logic id, op_t o);
    logic [32:0] m;
    exp_t e;
    m     = alu_model(o.a, o.b, o.op);
    e.id  = id;
    e.err = (o.op > 5'h0C);
    e.res = e.err ? 32'h0 : m[31:0];
    e.br  = (o.op >= 5'h08 && o.op <= 5'h0B) ? m[32] : 1'b0;
    return e;
  endfunction

  always_comb {alu_branch, alu_result} = alu_model(alu_a, alu_b, alu_op);

  task automatic chk(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Arbitration model: decides who must be granted and records accepted ops.
  always @(negedge clk) begin
    if (run) begin
      bit exp_free, e0, e1, w1;
      op_t o;
      chk("rsp_valid_state", rsp_valid, model_full);
      exp_free = !model_full || rsp_ready;
`ifdef ALU_ARB_FIXED_PRIO_EN
      w1 = req1_valid && !req0_valid;
`else
      w1 = (req0_valid && req1_valid) ? !last_gnt_m : req1_valid;
`endif
      e0 = exp_free && req0_valid && !w1;
      e1 = exp_free && req1_valid && w1;
      chk("grant", {req0_ready, req1_ready}, {e0, e1});
      chk("alu_mux", {alu_a, alu_b, alu_op},
          e1 ? {req1_a, req1_b, req1_op} : {req0_a, req0_b, req0_op});
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      if (acc0) begin o.a = req0_a; o.b = req0_b; o.op = req0_op; sb.push_back(expect_rsp(1'b0, o)); end
      if (acc1) begin o.a = req1_a; o.b = req1_b; o.op = req1_op; sb.push_back(expect_rsp(1'b1, o)); end
      if (acc0 || acc1) begin
        model_full = 1'b1;
        last_gnt_m = acc1;
      end else if (rsp_ready) begin
        model_full = 1'b0;
      end
    end
  end

  // Response monitor: the presented response must match the oldest expected entry.
  always @(negedge clk) begin
    if (run && rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual=id%0d res=%0h required=no response", rsp_id, rsp_result);
      end else begin
        chk("rsp", {rsp_id, rsp_result, rsp_branch, rsp_err}, sb[0]);
        if (rsp_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic drive_step();
    if (acc0) begin void'(opq0.pop_front()); req0_valid = 1'b0; end
    if (acc1) begin void'(opq1.pop_front()); req1_valid = 1'b0; end
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!req0_valid && opq0.size() > 0 && (gate_all || $urandom_range(0, 3) != 0)) begin
      req0_valid = 1'b1; {req0_a, req0_b, req0_op} = opq0[0];
    end else if (!req0_valid) begin
      req0_a = $urandom; req0_b = $urandom; req0_op = 5'($urandom);
    end
    if (!req1_valid && opq1.size() > 0 && (gate_all || $urandom_range(0, 3) != 0)) begin
      req1_valid = 1'b1; {req1_a, req1_b, req1_op} = opq1[0];
    end else if (!req1_valid) begin
      req1_a = $urandom; req1_b = $urandom; req1_op = 5'($urandom);
    end
    rsp_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_step();
  endtask

  task automatic drain();
    int n;
    gate_all  = 1'b1;
    ready_pct = 100;
    n = 0;
    while ((opq0.size() > 0 || opq1.size() > 0 || sb.size() > 0) && n < 500) begin
      step();
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d/%0d/%0d pending required=0", opq0.size(), opq1.size(), sb.size());
    end
  endtask

  task automatic do_reset();
    run        = 1'b0;
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready  = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_outputs", {rsp_valid, rsp_id, rsp_result, rsp_branch, rsp_err}, 36'h0);
    chk("reset_readies", {req0_ready, req1_ready}, 2'b00);
    @(posedge clk);
    #1;
    chk("reset_readies2", {req0_ready, req1_ready}, 2'b00);
    opq0.delete();
    opq1.delete();
    sb.delete();
    acc0 = 1'b0;
    acc1 = 1'b0;
    model_full = 1'b0;
    last_gnt_m = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    run   = 1'b1;
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.a  = $urandom;
    o.b  = ($urandom_range(0, 3) == 0) ? o.a : $urandom;
    o.op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(13, 31)) : 5'($urandom_range(0, 12));
    return o;
  endfunction

  initial begin
    int n;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    do_reset();

    // Contention straight after reset: port 0 wins (add 5+7), then port 1 (sub 9-4).
    opq0.push_back('{a: 32'd5, b: 32'd7, op: 5'h00});
    opq1.push_back('{a: 32'd9, b: 32'd4, op: 5'h01});
    drain();

    // Branch flag must not go stale: beq 3,3 then add 1,1.
    opq0.push_back('{a: 32'd3, b: 32'd3, op: 5'h08});
    opq0.push_back('{a: 32'd1, b: 32'd1, op: 5'h00});
    drain();

    // Illegal opcode on port 1.
    opq1.push_back('{a: 32'h1234, b: 32'h5678, op: 5'h1F});
    drain();

    // Back-pressure: consumer stalls for several cycles with both ports waiting.
    opq0.push_back('{a: 32'd10, b: 32'd20, op: 5'h00});
    opq0.push_back('{a: 32'd7, b: 32'd2, op: 5'h05});
    opq1.push_back('{a: 32'hF0, b: 32'h0F, op: 5'h03});
    gate_all  = 1'b1;
    ready_pct = 0;
    repeat (5) step();
    drain();

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 250; i++) begin
      opq0.push_back(rand_op());
      opq1.push_back(rand_op());
    end
    gate_all  = 1'b0;
    ready_pct = 60;
    n = 0;
    while ((opq0.size() > 0 || opq1.size() > 0) && n < 5000) begin
      step();
      n++;
    end
    drain();

    // Reset while a response is held: it must be discarded.
    opq0.push_back('{a: 32'd1, b: 32'd2, op: 5'h00});
    gate_all  = 1'b1;
    ready_pct = 0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("full_before_reset", rsp_valid, 1'b1);
    do_reset();

    // Sustained contention after reset.
    for (int i = 0; i < 4; i++) begin
      opq0.push_back(rand_op());
      opq1.push_back(rand_op());
    end
    drain();
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
